io_bus_controller: RTL



---
 rtl/io_bus_controller_pkg.sv | 18 +
 rtl/io_timeout_counter.sv | 38 +++
 rtl/io_bus_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/io_bus_controller_pkg.sv
// Shared types and constants for the I/O bus controller: FSM encoding,
// error-bit positions and default widths.
package io_bus_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } io_state_e;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_OVERRUN = 1;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 255;

endpackage

// File: rtl/io_timeout_counter.sv
// Per-phase cycle counter; expired_o flags the edge on which the phase has
// waited TIMEOUT edges and must give up.
module io_timeout_counter
  import io_bus_controller_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic i_CLOCK,
  input  logic i_RESET_N,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/io_bus_controller.sv
// Executes one four-phase device transaction per CPU strobe and toggles
// o_IOPAUSE on completion to release the clock divisor.
module io_bus_controller
  import io_bus_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET_N,
  input  logic                  i_REQ,
  input  logic                  i_WE,
  input  logic [ADDR_WIDTH-1:0] i_ADDR,
  input  logic [DATA_WIDTH-1:0] i_WDATA,
  input  logic                  i_ERR_CLR,
  output logic                  o_DEV_REQ,
  output logic                  o_DEV_WE,
  output logic [ADDR_WIDTH-1:0] o_DEV_ADDR,
  output logic [DATA_WIDTH-1:0] o_DEV_WDATA,
  input  logic                  i_DEV_ACK,
  input  logic [DATA_WIDTH-1:0] i_DEV_RDATA,
  output logic [DATA_WIDTH-1:0] o_RDATA,
  output logic                  o_IOPAUSE,
  output logic                  o_BUSY,
  output logic [1:0]            o_ERR
);

  io_state_e             state_q, state_d;
  logic                  dev_req_q, dev_req_d;
  logic                  dev_we_q, dev_we_d;
  logic [ADDR_WIDTH-1:0] dev_addr_q, dev_addr_d;
  logic [DATA_WIDTH-1:0] dev_wdata_q, dev_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  iopause_q, iopause_d;
  logic                  busy_q, busy_d;
  logic [1:0]            err_q, err_d;
  logic [1:0]            err_set;
  logic                  tmr_clr, tmr_en, tmr_expired;

  io_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_CLOCK   (i_CLOCK),
    .i_RESET_N (i_RESET_N),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    dev_req_d   = dev_req_q;
    dev_we_d    = dev_we_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;
    rdata_d     = rdata_q;
    iopause_d   = iopause_q;
    busy_d      = busy_q;
    err_set     = '0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    // A strobe outside IDLE (including the completing edge) is dropped.
    if (i_REQ && (state_q != IDLE)) begin
      err_set[ERR_OVERRUN] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tmr_clr = 1'b1;
        if (i_REQ) begin
          dev_we_d    = i_WE;
          dev_addr_d  = i_ADDR;
          dev_wdata_d = i_WDATA;
          dev_req_d   = 1'b1;
          busy_d      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (i_DEV_ACK || tmr_expired) begin
          if (!dev_we_q) begin
            rdata_d = i_DEV_ACK ? i_DEV_RDATA : '1;
          end
          err_set[ERR_TIMEOUT] = !i_DEV_ACK;
          dev_req_d = 1'b0;
          tmr_clr   = 1'b1;
          state_d   = RELEASE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RELEASE: begin
        if (!i_DEV_ACK || tmr_expired) begin
          err_set[ERR_TIMEOUT] = i_DEV_ACK;
          iopause_d = ~iopause_q;
          busy_d    = 1'b0;
          tmr_clr   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set beats clear on the same edge.
    err_d = (err_q & ~{2{i_ERR_CLR}}) | err_set;
  end

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q     <= IDLE;
      dev_req_q   <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
      rdata_q     <= '0;
      iopause_q   <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      dev_req_q   <= dev_req_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
      rdata_q     <= rdata_d;
      iopause_q   <= iopause_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign o_DEV_REQ   = dev_req_q;
  assign o_DEV_WE    = dev_we_q;
  assign o_DEV_ADDR  = dev_addr_q;
  assign o_DEV_WDATA = dev_wdata_q;
  assign o_RDATA     = rdata_q;
  assign o_IOPAUSE   = iopause_q;
  assign o_BUSY      = busy_q;
  assign o_ERR       = err_q;

endmodule
